// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control unit for the MIPS datapath.
//
// Walks each instruction through FETCH / DECODE / execute / memory / writeback
// states, talking to a variable-latency unified memory over a req/ack
// handshake. Counts retired instructions and pulses `illegal` on opcodes it
// does not implement.
//
// Optional feature: define MC_CTRL_MDU_EN to add mult/multu/div/divu and
// mfhi/mflo, together with the mdu_start / mdu_op ports.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   opcode, funct       instruction fields from the IR
//   alu_zero            ALU result is zero (beq decision)
//   mem_ack             memory finishes the current request this cycle
//   mem_req, mem_we     memory request (held until ack) and write qualifier
//   iord                memory address select: 0=PC, 1=ALUOut
//   ir_write, pc_write  IR load / PC update enables
//   pc_src              00=PC+4, 01=branch target, 10=jump target, 11=rs
//   alu_src_a/b, ext_op ALU operand selects and immediate extension mode
//   alu_op              ALU function
//   reg_write, reg_dst  register-file write enable and destination select
//   wb_src              writeback source: 00=ALUOut, 01=MDR, 10=PC, 11=HI/LO
//   illegal             one-cycle pulse on an unsupported instruction
//   retired_cnt         retired-instruction counter (wraps)
//   state_dbg           current state encoding
//   mdu_start, mdu_op   (MC_CTRL_MDU_EN only) multiply/divide unit control
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int CNT_W   = 32,
    parameter int MDU_LAT = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_src,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt,
`ifdef MC_CTRL_MDU_EN
    output logic             mdu_start,
    output logic [1:0]       mdu_op,
`endif
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC     = 4'd2,
        ALUWB    = 4'd3,
        ADDR     = 4'd4,
        MEMRD    = 4'd5,
        MEMWB    = 4'd6,
        MEMWR    = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        JR       = 4'd10,
        MDUSTART = 4'd11,
        MDUBUSY  = 4'd12
    } state_t;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_LUI  = 3'b111;
    localparam logic [2:0] ALU_SLL  = 3'b011;

    state_t state, state_nxt;
    logic   retire;

    // Instruction decode. The IR is stable from DECODE until the next FETCH
    // completes, so these terms are safe to use in every post-fetch state.
    logic is_rtype, is_addu, is_subu, is_sll, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic is_mf, is_mdu, is_alu;

    assign is_rtype = (opcode == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_sll   = is_rtype && (funct == 6'b000000);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);

`ifdef MC_CTRL_MDU_EN
    assign is_mf  = is_rtype && ((funct == 6'b010000) || (funct == 6'b010010));
    assign is_mdu = is_rtype && (funct[5:2] == 4'b0110);
`else
    assign is_mf  = 1'b0;
    assign is_mdu = 1'b0;
`endif

    assign is_alu = is_addu | is_subu | is_sll | is_ori | is_lui | is_mf;

`ifdef MC_CTRL_MDU_EN
    localparam int BW = $clog2(MDU_LAT + 1);
    logic [BW-1:0] busy_cnt;
    logic          busy_done;

    assign busy_done = (busy_cnt == BW'(MDU_LAT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            busy_cnt <= '0;
        else if (state == MDUSTART)
            busy_cnt <= '0;
        else if (state == MDUBUSY)
            busy_cnt <= busy_cnt + 1'b1;
    end
`else
    logic unused_mdu_lat;
    assign unused_mdu_lat = (MDU_LAT > 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (retire)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    assign state_dbg = state;

    // Outputs are forced low while reset_n is asserted so that a request in
    // flight is withdrawn immediately rather than at the next clock.
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        ext_op    = 1'b0;
        alu_op    = ALU_NONE;
        reg_write = 1'b0;
        reg_dst   = 2'b00;
        wb_src    = 2'b00;
        illegal   = 1'b0;
`ifdef MC_CTRL_MDU_EN
        mdu_start = 1'b0;
        mdu_op    = 2'b00;
`endif
        if (reset_n) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = ALU_ADD;
                    if (mem_ack) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    // Precompute the branch target into ALUOut.
                    alu_src_b = 2'b11;
                    alu_op    = ALU_ADD;
                    if (is_alu)                state_nxt = EXEC;
                    else if (is_lw || is_sw)   state_nxt = ADDR;
                    else if (is_beq)           state_nxt = BRANCH;
                    else if (is_j || is_jal)   state_nxt = JUMP;
                    else if (is_jr)            state_nxt = JR;
                    else if (is_mdu)           state_nxt = MDUSTART;
                    else begin
                        illegal   = 1'b1;
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = is_rtype ? 2'b00 : 2'b10;
                    ext_op    = is_ori;
                    if (is_addu)      alu_op = ALU_ADD;
                    else if (is_subu) alu_op = ALU_SUB;
                    else if (is_sll)  alu_op = ALU_SLL;
                    else if (is_ori)  alu_op = ALU_OR;
                    else if (is_lui)  alu_op = ALU_LUI;
                    state_nxt = ALUWB;
                end
                ALUWB: begin
                    reg_write = 1'b1;
                    wb_src    = is_mf ? 2'b11 : 2'b00;
                    reg_dst   = is_rtype ? 2'b01 : 2'b00;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
                ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = ALU_ADD;
                    state_nxt = is_lw ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ack) state_nxt = MEMWB;
                end
                MEMWB: begin
                    reg_write = 1'b1;
                    wb_src    = 2'b01;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
                MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ack) begin
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_write  = alu_zero;
                    pc_src    = 2'b01;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                    // PC already holds PC+4 here, which is the link value.
                    if (is_jal) begin
                        reg_write = 1'b1;
                        reg_dst   = 2'b10;
                        wb_src    = 2'b10;
                    end
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
                JR: begin
                    pc_write  = 1'b1;
                    pc_src    = 2'b11;
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end
`ifdef MC_CTRL_MDU_EN
                MDUSTART: begin
                    mdu_start = 1'b1;
                    mdu_op    = funct[1:0];
                    state_nxt = MDUBUSY;
                end
                MDUBUSY: begin
                    if (busy_done) begin
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                end
`endif
                default: state_nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- directed bench for mc_ctrl (default build, CNT_W=4).
// Inputs are driven 2 ns after the rising edge; outputs are sampled 1-2 ns
// later, well before the falling edge.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ack;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       illegal;
    logic [3:0] retired_cnt;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(4), .MDU_LAT(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .wb_src     (wb_src),
        .illegal    (illegal),
        .retired_cnt(retired_cnt),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // One j instruction with zero-wait memory, entered and left in FETCH.
    task automatic run_j;
        opcode  = 6'b000010;
        funct   = 6'b000000;
        mem_ack = 1'b1;
        #1;
        step; mem_ack = 1'b0; #1;
        step; #1;
        step; #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        opcode   = 6'b000000;
        funct    = 6'b000000;
        alu_zero = 1'b0;
        mem_ack  = 1'b0;

        // Reset state
        step; #1;
        check("rst_mem_req",  mem_req,     0);
        check("rst_pc_write", pc_write,    0);
        check("rst_alu_op",   alu_op,      0);
        check("rst_state",    state_dbg,   0);
        check("rst_cnt",      retired_cnt, 0);

        reset_n = 1'b1; #1;
        check("fetch_req",    mem_req,   1);
        check("fetch_iord",   iord,      0);
        check("fetch_srcb",   alu_src_b, 1);
        check("fetch_aluop",  alu_op,    3'b010);
        step; #1;
        check("fetch_hold",   mem_req,   1);
        check("fetch_noir",   ir_write,  0);

        // Reset asserted in the middle of a fetch request
        reset_n = 1'b0; #1;
        check("midreq_drop",  mem_req,   0);
        check("midreq_state", state_dbg, 0);
        step; reset_n = 1'b1; #1;
        check("rel_cnt",      retired_cnt, 0);
        check("rel_req",      mem_req,     1);

        // addu, zero-wait memory
        opcode = 6'b000000; funct = 6'b100001; mem_ack = 1'b1; #1;
        check("addu_c1_ir",   ir_write, 1);
        check("addu_c1_pc",   pc_write, 1);
        check("addu_c1_src",  pc_src,   0);
        step; mem_ack = 1'b0; #1;
        check("addu_c2_state", state_dbg, 1);
        check("addu_c2_srcb",  alu_src_b, 3);
        step; #1;
        check("addu_c3_srca",  alu_src_a, 1);
        check("addu_c3_srcb",  alu_src_b, 0);
        check("addu_c3_aluop", alu_op,    3'b010);
        step; #1;
        check("addu_c4_rw",    reg_write, 1);
        check("addu_c4_dst",   reg_dst,   1);
        check("addu_c4_wb",    wb_src,    0);
        check("addu_c4_cnt",   retired_cnt, 0);
        step; #1;
        check("addu_cnt",      retired_cnt, 1);
        check("addu_back",     state_dbg,   0);

        // lw, three wait cycles in FETCH and in MEMRD
        opcode = 6'b100011; funct = 6'b000000; mem_ack = 1'b0; #1;
        check("lw_fw0_req", mem_req, 1);
        for (int i = 1; i < 3; i++) begin
            step; #1;
            check("lw_fw_req", mem_req,  1);
            check("lw_fw_ir",  ir_write, 0);
        end
        step; mem_ack = 1'b1; #1;
        check("lw_c4_req", mem_req,  1);
        check("lw_c4_ir",  ir_write, 1);
        step; mem_ack = 1'b0; #1;
        check("lw_c5_state", state_dbg, 1);
        step; #1;
        check("lw_c6_state", state_dbg, 4);
        check("lw_c6_srcb",  alu_src_b, 2);
        check("lw_c6_ext",   ext_op,    0);
        for (int i = 0; i < 3; i++) begin
            step; #1;
            check("lw_mw_req",  mem_req, 1);
            check("lw_mw_iord", iord,    1);
            check("lw_mw_we",   mem_we,  0);
        end
        step; mem_ack = 1'b1; #1;
        check("lw_c10_req",  mem_req, 1);
        step; mem_ack = 1'b0; #1;
        check("lw_c11_rw",   reg_write, 1);
        check("lw_c11_wb",   wb_src,    1);
        check("lw_c11_dst",  reg_dst,   0);
        step; #1;
        check("lw_cnt",      retired_cnt, 2);

        // beq taken
        opcode = 6'b000100; mem_ack = 1'b1; #1;
        step; mem_ack = 1'b0; #1;
        step; alu_zero = 1'b1; #1;
        check("beq1_state", state_dbg, 8);
        check("beq1_pcw",   pc_write,  1);
        check("beq1_src",   pc_src,    1);
        check("beq1_aluop", alu_op,    3'b110);
        step; #1;
        check("beq1_cnt",   retired_cnt, 3);

        // beq not taken
        mem_ack = 1'b1; #1;
        step; mem_ack = 1'b0; #1;
        step; alu_zero = 1'b0; #1;
        check("beq0_pcw",   pc_write, 0);
        check("beq0_src",   pc_src,   1);
        step; #1;
        check("beq0_cnt",   retired_cnt, 4);

        // jal
        opcode = 6'b000011; mem_ack = 1'b1; #1;
        step; mem_ack = 1'b0; #1;
        step; #1;
        check("jal_dst", reg_dst,   2);
        check("jal_wb",  wb_src,    2);
        check("jal_src", pc_src,    2);
        check("jal_pcw", pc_write,  1);
        check("jal_rw",  reg_write, 1);
        step; #1;
        check("jal_cnt", retired_cnt, 5);

        // Unsupported opcode
        opcode = 6'b111111; mem_ack = 1'b1; #1;
        step; mem_ack = 1'b0; #1;
        check("ill_pulse",  illegal,   1);
        step; #1;
        check("ill_clear",  illegal,   0);
        check("ill_state",  state_dbg, 0);
        check("ill_cnt",    retired_cnt, 6);

        // sw, one wait cycle; a stray ack in ADDR must be ignored
        opcode = 6'b101011; mem_ack = 1'b1; #1;
        step; mem_ack = 1'b0; #1;
        step; mem_ack = 1'b1; #1;
        check("sw_addr_req", mem_req, 0);
        step; mem_ack = 1'b0; #1;
        check("sw_wr_state", state_dbg, 7);
        check("sw_wr_we",    mem_we,    1);
        check("sw_wr_iord",  iord,      1);
        step; mem_ack = 1'b1; #1;
        check("sw_wr_req",   mem_req,   1);
        step; mem_ack = 1'b0; #1;
        check("sw_cnt",      retired_cnt, 7);

        // ori
        opcode = 6'b001101; mem_ack = 1'b1; #1;
        step; mem_ack = 1'b0; #1;
        step; #1;
        check("ori_ext",   ext_op,    1);
        check("ori_aluop", alu_op,    3'b001);
        check("ori_srcb",  alu_src_b, 2);
        step; #1;
        check("ori_dst",   reg_dst,   0);
        check("ori_rw",    reg_write, 1);
        step; #1;
        check("ori_cnt",   retired_cnt, 8);

        // jr
        opcode = 6'b000000; funct = 6'b001000; mem_ack = 1'b1; #1;
        step; mem_ack = 1'b0; #1;
        step; #1;
        check("jr_state", state_dbg, 10);
        check("jr_src",   pc_src,    3);
        check("jr_pcw",   pc_write,  1);
        step; #1;
        check("jr_cnt",   retired_cnt, 9);

        // mult is unsupported without the MDU
        funct = 6'b011000; mem_ack = 1'b1; #1;
        step; mem_ack = 1'b0; #1;
        check("mult_ill", illegal, 1);
        step; #1;
        check("mult_cnt", retired_cnt, 10);

        // Counter wrap at CNT_W=4
        for (int i = 0; i < 6; i++) run_j;
        check("wrap_zero", retired_cnt, 0);
        opcode = 6'b000010; funct = 6'b000000; mem_ack = 1'b1; #1;
        step; mem_ack = 1'b0; #1;
        step; #1;
        check("j_src", pc_src,    2);
        check("j_rw",  reg_write, 0);
        step; #1;
        check("wrap_one", retired_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
